// File: rtl/led_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_display_ctrl
// Brief    : Registered N-LED bar driver: dark, hold, score, reset pattern,
//            blinking score and left/right chase with a step prescaler.
// Revision : 1.0 - initial release
// ============================================================================
module led_display_ctrl #(
    parameter int N_LEDS   = 7,
    parameter int STEP_DIV = 25000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_LEDS-1:0] score,
    input  logic [2:0]        led_ctrl,
    output logic [N_LEDS-1:0] led_out,
    output logic              step_tick
);
    localparam int c_cnt_w = $clog2(STEP_DIV);
    localparam int c_pos_w = $clog2(N_LEDS);

    localparam logic [2:0] c_dark     = 3'b000;
    localparam logic [2:0] c_hold     = 3'b001;
    localparam logic [2:0] c_score    = 3'b010;
    localparam logic [2:0] c_rstpat   = 3'b011;
    localparam logic [2:0] c_blink    = 3'b100;
    localparam logic [2:0] c_chase_l  = 3'b101;
    localparam logic [2:0] c_chase_r  = 3'b110;
    localparam logic [2:0] c_hold_alt = 3'b111;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STEP_DIV - 1);
    localparam logic [c_pos_w-1:0] c_pos_last = c_pos_w'(N_LEDS - 1);
    localparam logic [N_LEDS-1:0]  c_one      = N_LEDS'(1);

    logic [2:0]         r_mode_q, w_mode;
    logic [c_cnt_w-1:0] r_cnt,    w_cnt;
    logic               r_phase,  w_phase;
    logic [c_pos_w-1:0] r_pos,    w_pos;
    logic [N_LEDS-1:0]  r_led,    w_led;
    logic               r_tick,   w_tick;
    logic [N_LEDS-1:0]  w_rstpat;
    logic               w_animated;

    // Alternating pattern with bit 0 lit.
    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_rstpat
        assign w_rstpat[gi] = ((gi % 2) == 0);
    end

    assign w_animated = (r_mode_q == c_blink) || (r_mode_q == c_chase_l) ||
                        (r_mode_q == c_chase_r);

    always_comb begin
        w_mode  = r_mode_q;
        w_cnt   = r_cnt;
        w_phase = r_phase;
        w_pos   = r_pos;
        w_tick  = 1'b0;
        w_led   = r_led;

        if (led_ctrl != r_mode_q) begin
            w_mode  = led_ctrl;
            w_cnt   = '0;
            w_phase = 1'b1;
            w_pos   = (led_ctrl == c_chase_l) ? '0 : c_pos_last;
        end else if (w_animated) begin
            if (r_cnt == c_cnt_last) begin
                w_cnt  = '0;
                w_tick = 1'b1;
                if (r_mode_q == c_blink) begin
                    w_phase = ~r_phase;
                end else if (r_mode_q == c_chase_l) begin
                    w_pos = (r_pos == c_pos_last) ? '0 : r_pos + 1'b1;
                end else begin
                    w_pos = (r_pos == '0) ? c_pos_last : r_pos - 1'b1;
                end
            end else begin
                w_cnt = r_cnt + 1'b1;
            end
        end else if ((r_mode_q != c_hold) && (r_mode_q != c_hold_alt)) begin
            w_cnt = '0;
        end

        // Output is derived from the post-edge state so latency stays at 1 clk.
        case (w_mode)
            c_dark:               w_led = '0;
            c_score:              w_led = score;
            c_rstpat:             w_led = w_rstpat;
            c_blink:              w_led = w_phase ? score : '0;
            c_chase_l, c_chase_r: w_led = c_one << w_pos;
            c_hold, c_hold_alt:   w_led = r_led;
            default:              w_led = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q <= c_dark;
            r_cnt    <= '0;
            r_phase  <= 1'b1;
            r_pos    <= '0;
            r_led    <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_mode_q <= w_mode;
            r_cnt    <= w_cnt;
            r_phase  <= w_phase;
            r_pos    <= w_pos;
            r_led    <= w_led;
            r_tick   <= w_tick;
        end
    end

    assign led_out   = r_led;
    assign step_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_display_ctrl
// Brief    : Scoreboard bench for led_display_ctrl (N_LEDS=7, STEP_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_display_ctrl;
    localparam int N   = 7;
    localparam int DIV = 4;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic [N-1:0] score    = '0;
    logic [2:0]   led_ctrl = 3'b000;
    logic [N-1:0] led_out;
    logic         step_tick;

    logic [N:0]   exp_q[$];
    logic [N:0]   exp_v;
    int           n_cmp = 0;
    int           n_err = 0;

    led_display_ctrl #(.N_LEDS(N), .STEP_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .score     (score),
        .led_ctrl  (led_ctrl),
        .led_out   (led_out),
        .step_tick (step_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one cycle of stimulus and returns 1 time unit after the edge.
    task automatic cyc(input logic [2:0] c, input logic [N-1:0] s);
        led_ctrl = c;
        score    = s;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] onehot(input int p);
        logic [N-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        led_ctrl = 3'b011;
        score = 7'b1111111;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back({7'b0000000, 1'b0});
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({led_out, step_tick} !== exp_v) begin
            n_err++;
            $display("FAIL reset: led=%b tick=%b, expected led=%b tick=%b",
                     led_out, step_tick, exp_v[N:1], exp_v[0]);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_rstpat();
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back({7'b1010101, 1'b0});
            cyc(3'b011, 7'b0110110);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if ({led_out, step_tick} !== exp_v) begin
                n_err++;
                $display("FAIL rstpat k=%0d: led=%b tick=%b, expected led=%b tick=%b",
                         k, led_out, step_tick, exp_v[N:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_score();
        logic [N-1:0] s;
        for (int k = 0; k < 6; k++) begin
            s = (k < 3) ? 7'b0011100 : 7'b1100011;
            exp_q.push_back({s, 1'b0});
            cyc(3'b010, s);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if ({led_out, step_tick} !== exp_v) begin
                n_err++;
                $display("FAIL score k=%0d: led=%b tick=%b, expected led=%b tick=%b",
                         k, led_out, step_tick, exp_v[N:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_blink();
        logic [N-1:0] s;
        logic         on;
        for (int k = 0; k < 11; k++) begin
            s  = (k >= 9) ? 7'b0101010 : 7'b1111111;
            on = ((k / DIV) % 2) == 0;
            exp_q.push_back({on ? s : 7'b0000000, (k > 0) && (k % DIV == 0)});
            cyc(3'b100, s);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if ({led_out, step_tick} !== exp_v) begin
                n_err++;
                $display("FAIL blink k=%0d: led=%b tick=%b, expected led=%b tick=%b",
                         k, led_out, step_tick, exp_v[N:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_chase_l(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            exp_q.push_back({onehot((k / DIV) % N), (k > 0) && (k % DIV == 0)});
            cyc(3'b101, 7'(k * 37));
            exp_v = exp_q.pop_front();
            n_cmp++;
            if ({led_out, step_tick} !== exp_v) begin
                n_err++;
                $display("FAIL chase_l k=%0d: led=%b tick=%b, expected led=%b tick=%b",
                         k, led_out, step_tick, exp_v[N:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_chase_r();
        for (int k = 0; k < 30; k++) begin
            exp_q.push_back({onehot(N - 1 - ((k / DIV) % N)), (k > 0) && (k % DIV == 0)});
            cyc(3'b110, 7'b1111111);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if ({led_out, step_tick} !== exp_v) begin
                n_err++;
                $display("FAIL chase_r k=%0d: led=%b tick=%b, expected led=%b tick=%b",
                         k, led_out, step_tick, exp_v[N:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_hold();
        test_chase_l(10);
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back({7'b0000100, 1'b0});
            cyc((k < 6) ? 3'b001 : 3'b111, (k % 2 == 0) ? 7'b1111111 : 7'b0000000);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if ({led_out, step_tick} !== exp_v) begin
                n_err++;
                $display("FAIL hold k=%0d: led=%b tick=%b, expected led=%b tick=%b",
                         k, led_out, step_tick, exp_v[N:1], exp_v[0]);
            end
        end
        test_chase_l(6);
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ctrl_t[8];
        logic [N-1:0] led_t[8];
        ctrl_t = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001, 3'b000};
        led_t  = '{7'b0000000, 7'b1011001, 7'b1010101, 7'b1011001,
                   7'b0000001, 7'b1000000, 7'b1000000, 7'b0000000};
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({led_t[k], 1'b0});
            cyc(ctrl_t[k], 7'b1011001);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if ({led_out, step_tick} !== exp_v) begin
                n_err++;
                $display("FAIL back_to_back k=%0d: led=%b tick=%b, expected led=%b tick=%b",
                         k, led_out, step_tick, exp_v[N:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_async_reset();
        test_chase_l(13);
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back({7'b0000000, 1'b0});
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({led_out, step_tick} !== exp_v) begin
            n_err++;
            $display("FAIL async_reset: led=%b tick=%b, expected led=%b tick=%b",
                     led_out, step_tick, exp_v[N:1], exp_v[0]);
        end
        @(posedge clk);
        #1;
        led_ctrl = 3'b000;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({7'b0000000, 1'b0});
            cyc(3'b000, 7'b1111111);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if ({led_out, step_tick} !== exp_v) begin
                n_err++;
                $display("FAIL release_dark k=%0d: led=%b tick=%b, expected led=%b tick=%b",
                         k, led_out, step_tick, exp_v[N:1], exp_v[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rstpat();
        test_score();
        test_blink();
        test_chase_l(30);
        test_chase_r();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
